// File: rtl/if_slice.sv
`timescale 1ns/1ps
// if_slice -- instruction-fetch stage feeding the decode slice.
//
// Holds the program counter, issues one outstanding request at a time to a
// variable-latency instruction memory, and buffers the returned words in a
// small FIFO. The FIFO head drives decode as {instr, fetched PC + 1}.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   stall         decode cannot accept; head is held, fetching continues
//   redirect      load redirect_pc, flush buffer, drop any in-flight word
//   redirect_pc   new fetch address
//   imem_req      one-cycle request strobe (combinational, same cycle as issue)
//   imem_addr     request address, meaningful only with imem_req
//   imem_valid    response strobe, 1+ cycles after imem_req
//   imem_rdata    response word
//   instr_out     instruction to decode (BUBBLE when nothing valid)
//   PC_inc_out    fetched PC + 1 (0 when nothing valid)
//   fb_empty      fetch buffer empty
module if_slice #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          FB_DEPTH = 2,
    parameter logic [15:0] BUBBLE   = 16'hF000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr_out,
    output logic [15:0] PC_inc_out,
    output logic        fb_empty
);

    localparam int PW = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
    localparam int CW = $clog2(FB_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    typedef struct packed {
        logic [15:0] word;
        logic [15:0] pc_inc;
    } fb_entry_t;

    fb_entry_t      r_fb [FB_DEPTH];
    logic [PW-1:0]  r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic [15:0]    r_pc, r_req_addr;
    state_t         r_state;
    // A request issued before a reset may still answer afterwards; that one
    // stray response is legal and must not trip the protocol check.
    logic           r_orphan;

    logic           w_empty, w_push, w_pop, w_issue, w_show;
    logic [CW-1:0]  w_count_next;
    fb_entry_t      w_head;

    assign w_empty      = (r_count == '0);
    assign w_pop        = !w_empty && !stall && !redirect;
    assign w_push       = (r_state == WAIT) && imem_valid && !redirect;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    // Issue decision: IDLE looks at current occupancy; WAIT chains the next
    // request onto the returning word so a 1-cycle memory sustains 1 IPC.
    always_comb begin
        w_issue = 1'b0;
        unique case (r_state)
            IDLE:    w_issue = !redirect && (r_count < CW'(FB_DEPTH));
            WAIT:    w_issue = w_push && (w_count_next < CW'(FB_DEPTH));
            default: w_issue = 1'b0;
        endcase
        if (rst) w_issue = 1'b0;
    end

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;

    // Redirect cycle shows BUBBLE even though the buffer is not flushed yet.
    assign w_head     = r_fb[r_rd_ptr];
    assign w_show     = !w_empty && !redirect;
    assign instr_out  = w_show ? w_head.word   : BUBBLE;
    assign PC_inc_out = w_show ? w_head.pc_inc : 16'h0000;
    assign fb_empty   = w_empty;

    // Buffer storage needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fb[r_wr_ptr] <= '{word: imem_rdata, pc_inc: r_req_addr + 16'd1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_orphan   <= 1'b1;
        end else begin
            if (w_issue) begin
                r_pc       <= r_pc + 16'd1;
                r_req_addr <= r_pc;
            end
            if (redirect) r_pc <= redirect_pc;

            if (redirect) begin
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
                r_count <= w_count_next;
            end

            if (imem_valid || w_issue) r_orphan <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    if (w_issue) r_state <= WAIT;
                end
                WAIT: begin
                    // Response always ends this request; a same-cycle
                    // redirect suppresses both push and chained issue.
                    if (imem_valid)    r_state <= w_issue ? WAIT : IDLE;
                    else if (redirect) r_state <= DISCARD;
                end
                DISCARD: begin
                    if (imem_valid) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A response with nothing outstanding is a memory-side protocol error.
    a_no_spurious_valid: assert property (@(posedge clk) disable iff (rst)
        !(imem_valid && (r_state == IDLE) && !r_orphan))
        else $error("if_slice: imem_valid with no request outstanding");

endmodule

// File: tb/tb_if_slice.sv
`timescale 1ns/1ps
module tb_if_slice;

    localparam logic [15:0] BUBBLE = 16'hF000;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic [15:0] instr_out, PC_inc_out;
    logic        fb_empty;

    always #5 clk = ~clk;

    if_slice #(.RESET_PC(16'h0000), .FB_DEPTH(2), .BUBBLE(BUBBLE)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .PC_inc_out(PC_inc_out), .fb_empty(fb_empty)
    );

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    int mcnt   = 0;
    logic [15:0] maddr;
    logic [31:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic expect_word(input logic [15:0] w, input logic [15:0] p);
        exp_q.push_back({w, p});
    endtask

    // Memory model: mem[a] = 16'h1000 + a, answers 'lat' cycles after request.
    initial begin
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            imem_valid = 1'b0;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = 16'h1000 + maddr;
                end
            end
            #1;
            if (imem_req) begin
                mcnt  = lat;
                maddr = imem_addr;
            end
        end
    end

    // Monitor: every consumed head is compared with the scoreboard front;
    // whenever nothing valid is shown the outputs must be BUBBLE/0.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (fb_empty || redirect)
                chk("bubble", {instr_out, PC_inc_out}, {BUBBLE, 16'h0000});
            if (!fb_empty && !stall && !redirect && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop actual=%h expected=none", {instr_out, PC_inc_out});
                end else begin
                    chk("pop", {instr_out, PC_inc_out}, exp_q.pop_front());
                end
            end
        end
    end

    // Called at a negedge; returns at negedge+1 of the issuing cycle.
    task automatic wait_req(input logic [15:0] a, input string nm, output int waited);
        for (waited = 0; waited < 50; waited++) begin
            #1;
            if (imem_req) break;
            @(negedge clk);
        end
        if (waited >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s actual=no_request expected=%h", nm, a);
        end else begin
            chk(nm, imem_addr, a);
        end
    endtask

    // Let decode consume everything expected, then stall at once so no
    // further word is consumed before the next redirect flushes the buffer.
    task automatic drain_and_stall(input string nm);
        int t;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        stall = 1'b1;
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL %s actual=%0d_left expected=0_left", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Redirect while stalled, then release; returns at the first issue.
    task automatic redir(input logic [15:0] pc, input string nm);
        int w;
        redirect    = 1'b1;
        redirect_pc = pc;
        @(negedge clk);
        redirect = 1'b0;
        stall    = 1'b0;
        chk({nm, "_flushed"}, fb_empty, 1'b1);
        wait_req(pc, {nm, "_addr"}, w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_instr", instr_out, BUBBLE);
        chk("rst_pcinc", PC_inc_out, 16'h0000);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_empty", fb_empty, 1'b1);

        // Streaming with a 1-cycle memory
        expect_word(16'h1000, 16'h0001);
        expect_word(16'h1001, 16'h0002);
        expect_word(16'h1002, 16'h0003);
        @(negedge clk);
        rst = 1'b0;
        wait_req(16'h0000, "addr0", w);
        chk("addr0_now", w, 0);
        @(negedge clk);
        wait_req(16'h0001, "addr1", w);
        @(negedge clk);
        wait_req(16'h0002, "addr2", w);
        chk("first_word_lat", {instr_out, PC_inc_out}, {16'h1000, 16'h0001});
        drain_and_stall("drain_a");

        // Stall holds the head while the buffer fills and fetch stops
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_head", {instr_out, PC_inc_out}, {16'h1003, 16'h0004});
            chk("stall_nonempty", fb_empty, 1'b0);
            if (i > 0) chk("stall_noreq", imem_req, 1'b0);
            @(negedge clk);
        end
        expect_word(16'h1003, 16'h0004);
        expect_word(16'h1004, 16'h0005);
        expect_word(16'h1005, 16'h0006);
        expect_word(16'h1006, 16'h0007);
        stall = 1'b0;
        drain_and_stall("drain_b");

        // 3-cycle memory, redirect one cycle after an issue -> discard
        repeat (2) @(negedge clk);
        lat = 3;
        expect_word(16'h1040, 16'h0041);
        expect_word(16'h1041, 16'h0042);
        redir(16'h0030, "r30");
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h0040;
        #1 chk("redir_noreq", imem_req, 1'b0);
        @(negedge clk);
        redirect = 1'b0;
        #1 chk("discard_noreq1", imem_req, 1'b0);
        @(negedge clk);
        #1 chk("discard_noreq2", imem_req, 1'b0);
        @(negedge clk);
        wait_req(16'h0040, "discard_reissue", w);
        chk("discard_reissue_now", w, 0);
        drain_and_stall("drain_c");

        // Redirect in the same cycle as the response
        repeat (2) @(negedge clk);
        expect_word(16'h1060, 16'h0061);
        expect_word(16'h1061, 16'h0062);
        redir(16'h0050, "r50");
        repeat (3) @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h0060;
        #1 chk("rv_noreq", imem_req, 1'b0);
        @(negedge clk);
        redirect = 1'b0;
        wait_req(16'h0060, "rv_reissue", w);
        chk("rv_idle_now", w, 0);
        drain_and_stall("drain_d");

        // PC wrap at 16'hFFFF
        repeat (2) @(negedge clk);
        lat = 1;
        expect_word(16'h0FFE, 16'hFFFF);
        expect_word(16'h0FFF, 16'h0000);
        expect_word(16'h1000, 16'h0001);
        redir(16'hFFFE, "rwrap");
        @(negedge clk);
        wait_req(16'hFFFF, "wrap_ffff", w);
        @(negedge clk);
        wait_req(16'h0000, "wrap_0000", w);
        drain_and_stall("drain_e");

        // Reset while waiting; late response after reset is ignored
        repeat (2) @(negedge clk);
        lat = 3;
        redir(16'h0070, "r70");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_req", imem_req, 1'b0);
        chk("rstw_empty", fb_empty, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        redirect = 1'b1; redirect_pc = 16'h0000;
        @(negedge clk);
        #1;
        chk("late_noreq", imem_req, 1'b0);
        chk("late_ignored", fb_empty, 1'b1);
        @(negedge clk);
        redirect = 1'b0;
        expect_word(16'h1000, 16'h0001);
        expect_word(16'h1001, 16'h0002);
        wait_req(16'h0000, "restart_addr", w);
        chk("restart_now", w, 0);
        drain_and_stall("drain_f");
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
